queue_drain_tx: RTL and testbench

Downstream consumer of the byte queue (`queue`, wrapped with `deserializer` in `top`). It watches the queue length, requests one byte at a time through the queue's `dequeue_in`, and captures the byte from `data_out`. It then transmits the byte as a framed serial stream: start bit, 8 data bits MSB first, stop bit. It closes the path deserializer → queue → serial line, and runs on one system clock independent of the queue's internally divided clock.

---
 rtl/queue_tx_pkg.sv | 9 +
 rtl/queue_drain_tx_bit_timer.sv | 34 +++
 rtl/queue_drain_tx.sv | 137 +++++++++++++
 tb/tb_queue_drain_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_tx_pkg.sv
// Shared types and default timing constants for the queue drain transmitter.
package queue_tx_pkg;

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} tx_state_t;

  localparam int unsigned BIT_CYCLES_DEF  = 10;
  localparam int unsigned REQ_TIMEOUT_DEF = 255;

endpackage

// File: rtl/queue_drain_tx_bit_timer.sv
// Bit-period down-counter: loaded with BIT_CYCLES-1, ticks at zero and reloads itself.
module bit_timer #(
  parameter int BIT_CYCLES = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic load_in,
  input  logic run_in,
  output logic tick_out
);

  localparam int CNT_W = $clog2(BIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    tick_out = run_in && (cnt_q == '0);
    if (load_in || tick_out) begin
      cnt_d = CNT_W'(BIT_CYCLES - 1);
    end else if (run_in) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/queue_drain_tx.sv
// Pulls bytes from the queue one at a time and sends each as a start/8 data (MSB first)/stop frame.
module queue_drain_tx
  import queue_tx_pkg::*;
#(
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int REQ_TIMEOUT = REQ_TIMEOUT_DEF,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic              serial_out,
  output logic              busy_out,
  output logic              err_out
);

  localparam int CYC_MAX = (BIT_CYCLES > REQ_TIMEOUT) ? BIT_CYCLES : REQ_TIMEOUT;
  localparam int CYC_W   = $clog2(CYC_MAX);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  tx_state_t         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  len_snap_q, len_snap_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dequeue_q, dequeue_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              tick;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .load_in  (state_q == LOAD),
    .run_in   ((state_q == START) || (state_q == DATA) || (state_q == STOP)),
    .tick_out (tick)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_cnt_d  = bit_cnt_q;
    len_snap_d = len_snap_q;
    shreg_d    = shreg_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in && (len_in != '0)) begin
          state_d    = REQ;
          len_snap_d = len_in;
        end
      end
      // Any length change (drain or a concurrent enqueue) means the grant happened.
      REQ: begin
        if (len_in != len_snap_q) begin
          state_d = LOAD;
        end else if (cyc_q == CYC_W'(REQ_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      LOAD: begin
        shreg_d = data_in;
        state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cyc_d     = '0;
      bit_cnt_d = '0;
    end

    // Outputs are decoded from next-state so the registered values line up with state_q.
    dequeue_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_d[DATA_W-1];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_cnt_q <= '0;
      dequeue_q <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_cnt_q <= bit_cnt_d;
      dequeue_q <= dequeue_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    len_snap_q <= len_snap_d;
    shreg_q    <= shreg_d;
  end

  assign dequeue_out = dequeue_q;
  assign serial_out  = serial_q;
  assign busy_out    = busy_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_queue_drain_tx.sv
// Directed bench for queue_drain_tx: reset, single byte, back-to-back, timeout, enable drop, async reset.
module tb_queue_drain_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable_in;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       dequeue_out;
  logic       serial_out;
  logic       busy_out;
  logic       err_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  queue_drain_tx #(
    .BIT_CYCLES  (10),
    .REQ_TIMEOUT (255),
    .DATA_W      (8),
    .LEN_W       (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_in   (enable_in),
    .len_in      (len_in),
    .data_in     (data_in),
    .dequeue_out (dequeue_out),
    .serial_out  (serial_out),
    .busy_out    (busy_out),
    .err_out     (err_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_deq(input string tag);
    int n;
    n = 0;
    while (dequeue_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1({tag, "_req_seen"}, dequeue_out, 1'b1);
  endtask

  // Queue model drops len 4 clocks after the request rises; then the whole frame is checked bit by bit.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic [7:0] next_b,
                           input int en_drop_bit);
    int         hi;
    int         good;
    logic [9:0] fr;
    wait_deq(tag);
    hi = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      hi += int'(dequeue_out);
      if (i == 4) len_in = len_in - 4'd1;
    end
    tick();
    chk1({tag, "_deq_fall"}, dequeue_out, 1'b0);
    chk({tag, "_deq_clocks"}, hi, 5);
    fr = {1'b0, b, 1'b1};
    for (int j = 0; j < 10; j++) begin
      good = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (j == 0 && c == 0) data_in = next_b;
        if (j == en_drop_bit && c == 4) enable_in = 1'b0;
        good += int'(serial_out === fr[9-j]);
      end
      chk($sformatf("%s_bit%0d", tag, j), good, 10);
    end
  endtask

  initial begin
    int s_bad, d_bad, b_bad, e_bad;
    int hi, n, errs;

    reset     = 1'b1;
    enable_in = 1'b1;
    len_in    = 4'd3;
    data_in   = 8'h00;
    #2 reset = 1'b0;

    // Reset held for 5 clocks with a non-empty queue.
    s_bad = 0; d_bad = 0; b_bad = 0; e_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      s_bad += int'(serial_out !== 1'b1);
      d_bad += int'(dequeue_out !== 1'b0);
      b_bad += int'(busy_out !== 1'b0);
      e_bad += int'(err_out !== 1'b0);
    end
    chk("rst_serial", s_bad, 0);
    chk("rst_dequeue", d_bad, 0);
    chk("rst_busy", b_bad, 0);
    chk("rst_err", e_bad, 0);

    // Single byte A5.
    len_in  = 4'd1;
    data_in = 8'hA5;
    reset   = 1'b1;
    run_frame("single", 8'hA5, 8'h00, -1);
    tick();
    chk1("single_idle_busy", busy_out, 1'b0);
    chk1("single_no_req", dequeue_out, 1'b0);

    // Back-to-back 3C then FF, one IDLE clock between frames.
    len_in  = 4'd2;
    data_in = 8'h3C;
    run_frame("b2b0", 8'h3C, 8'hFF, -1);
    tick();
    chk1("b2b_gap_busy", busy_out, 1'b0);
    chk1("b2b_gap_deq", dequeue_out, 1'b0);
    tick();
    chk1("b2b_gap_req", dequeue_out, 1'b1);
    run_frame("b2b1", 8'hFF, 8'h00, -1);
    tick();
    chk1("b2b_end_busy", busy_out, 1'b0);
    tick();
    chk1("b2b_end_deq", dequeue_out, 1'b0);

    // Timeout: len never changes.
    len_in = 4'd3;
    wait_deq("tmo");
    hi = 0; n = 0; errs = 0;
    while (dequeue_out === 1'b1 && n < 400) begin
      hi++;
      errs += int'(err_out);
      tick();
      n++;
    end
    chk("tmo_req_clocks", hi, 255);
    chk("tmo_err_early", errs, 0);
    chk1("tmo_err_pulse", err_out, 1'b1);
    chk1("tmo_idle_busy", busy_out, 1'b0);
    tick();
    chk1("tmo_err_clear", err_out, 1'b0);
    chk1("tmo_rereq", dequeue_out, 1'b1);

    reset = 1'b0;
    tick();
    tick();

    // Enable drops during DATA bit 3 with bytes still queued.
    len_in    = 4'd3;
    data_in   = 8'h81;
    enable_in = 1'b1;
    reset     = 1'b1;
    run_frame("endrop", 8'h81, 8'h00, 4);
    tick();
    chk1("endrop_busy_after", busy_out, 1'b0);
    d_bad = 0; b_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      d_bad += int'(dequeue_out);
      b_bad += int'(busy_out);
    end
    chk("endrop_no_req", d_bad, 0);
    chk("endrop_no_busy", b_bad, 0);

    // Asynchronous reset in DATA bit 5 (frame slot 6), between clock edges.
    enable_in = 1'b1;
    data_in   = 8'hC3;
    wait_deq("rmf");
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) len_in = len_in - 4'd1;
    end
    tick();
    for (int i = 0; i < 65; i++) tick();
    chk1("rmf_pre_serial", serial_out, 1'b0);
    chk1("rmf_pre_busy", busy_out, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("rmf_async_serial", serial_out, 1'b1);
    chk1("rmf_async_busy", busy_out, 1'b0);
    chk1("rmf_async_deq", dequeue_out, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk1("rmf_rereq", dequeue_out, 1'b1);
    chk1("rmf_rereq_busy", busy_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
